colorclk_ctrl: RTL and testbench
================================

// Module: colorclk_ctrl
// PURPOSE
// - Sequencer for the colour-subcarrier DDS (29-bit phase accumulator, MSB = clkcolor4x).
// - Owns the DDS increment word, enable and phase-clear; applies PAL/NTSC and enable changes
//   glitch-free, only at a frame boundary, muting the carrier across the switch.
// - Sits between the config register bank (async to clk) and the DDS in the video wrapper.
// PARAMETERS
// - INC_PAL       95211238  29-bit increment for 17.734475 MHz (4x PAL subcarrier)
// - INC_NTSC      76870144  29-bit increment for 14.31818 MHz (4x NTSC subcarrier)
// - MUTE_CYCLES   16        cycles dds_en is held low before the new word is loaded (>=1)
// - SETTLE_CYCLES 1024      cycles after load before ready asserts (>=1)
// - WAIT_TIMEOUT  1048575   max cycles spent waiting for vsync before forcing the switch
// PORTS
// - clk        in   1   fastest system clock (DDS clock)
// - rst_n      in   1   asynchronous, active-low reset
// - mode_req   in   1   requested standard, 0=PAL 1=NTSC (async, synchronised inside)
// - en_req     in   1   requested carrier enable (async, synchronised inside)
// - vsync      in   1   frame sync, clk domain; rising edge = safe switch point
// - dds_inc    out  29  increment word to the DDS accumulator
// - dds_en     out  1   DDS output enable (0 forces clkcolor4x high)
// - dds_clr    out  1   one-cycle pulse: DDS clears accumulator to 0
// - mode_cur   out  1   standard currently applied
// - busy       out  1   1 while a change is pending or in progress
// - ready      out  1   carrier applied, enabled and settled
// BEHAVIOUR
// - Reset: dds_inc=INC_PAL, dds_en=0, dds_clr=0, mode_cur=0, en_cur=0, busy=0, ready=0,
//   state=RUN, all counters 0, synchroniser flops 0.
// - mode_req/en_req pass 2-FF synchronisers (2 cycles latency); vsync rising edge detected
//   with a 1-cycle registered delay (vs_rise).
// - Pending = {en_s,mode_s} != {en_cur,mode_cur}, evaluated in RUN only.
// - RUN: dds_en=en_cur; ready=en_cur; busy=0. Pending -> WAIT_VS (busy=1 same edge), clear tmo.
// - WAIT_VS: tmo++ per cycle; vs_rise OR tmo==WAIT_TIMEOUT -> MUTE, cnt=0. dds_en unchanged.
//   Request reverting to applied value while in WAIT_VS -> back to RUN, no switch.
// - MUTE: dds_en=0, ready=0; cnt++; cnt==MUTE_CYCLES-1 -> LOAD.
// - LOAD (1 cycle): sample {en_s,mode_s} into {en_cur,mode_cur}; dds_inc=base(mode_s)
//   (+trim if enabled); dds_clr=1 for this cycle only -> SETTLE, cnt=0.
// - SETTLE: dds_en=en_cur, ready=0; cnt++; cnt==SETTLE_CYCLES-1 -> RUN.
// - Requests changing during MUTE/SETTLE are not applied mid-sequence; re-evaluated in RUN
//   (new full sequence). Vsync edges outside WAIT_VS ignored.
// - Disable request (en 1->0) follows the same path; LOAD with en_cur=0 leaves dds_en=0 and
//   SETTLE still runs, ready stays 0.
// - dds_inc only ever changes in LOAD; never changes while dds_en=1.
// - Reset mid-sequence: immediate return to reset values; DDS muted (dds_en=0).
// - Counters sized $clog2 of their parameter; no wrap in normal use (compare terminates).
// CONFIGURATION
// - COLORCLK_TRIM_EN defined: extra port trim in 8 (signed, async, synchronised like mode_req);
//   LOAD sets dds_inc = base + sign-extended trim (mod 2^29); trim change counts as pending.
// - COLORCLK_TRIM_EN undefined: no trim port; dds_inc is exactly INC_PAL or INC_NTSC.
// TESTING
// - Reset, en_req=1 mode_req=0, no vsync -> after sync+WAIT_TIMEOUT+MUTE_CYCLES+1 dds_clr
//   pulses once, dds_inc=95211238, ready=1 SETTLE_CYCLES later.
// - Running PAL, mode_req->1, vsync edge 500 cycles later -> dds_en low 16 cycles, then
//   dds_inc=76870144, mode_cur=1, ready after 1024 cycles; dds_inc stable while dds_en=1.
// - mode_req toggles 1 then back to 0 before any vsync -> returns to RUN, no dds_clr, no mute.
// - mode_req changes during SETTLE -> first sequence completes, ready=1 one cycle in RUN is
//   not guaranteed; second sequence starts, final mode_cur matches last request.
// - en_req->0 -> at vsync dds_en=0, ready=0, busy drops after settle; rst_n low mid-MUTE ->
//   all outputs at reset values asynchronously.
// - With COLORCLK_TRIM_EN, trim=-3 PAL -> dds_inc=95211235; trim change alone triggers sequence.

Source files
------------

// File: rtl/colorclk_ctrl_if.sv
// Colour-clock sequencer bus: config requests and frame sync in, DDS control and status out.
// Optional macro: COLORCLK_TRIM_EN adds the signed 8-bit trim request.
//   master : the sequencer (colorclk_ctrl)
//   slave  : config bank / video wrapper / DDS side
// Signals:
//   mode_req  requested standard (0=PAL, 1=NTSC), async to clk
//   en_req    requested carrier enable, async to clk
//   vsync     frame sync in clk domain, rising edge = safe switch point
//   trim      signed increment trim, async (COLORCLK_TRIM_EN only)
//   dds_inc   29-bit increment word to the DDS accumulator
//   dds_en    DDS output enable
//   dds_clr   one-cycle accumulator clear pulse
//   mode_cur  standard currently applied
//   busy      change pending or in progress
//   ready     carrier applied, enabled and settled
interface colorclk_ctrl_if;
   localparam int unsigned INC_W = 29;

   logic             mode_req;
   logic             en_req;
   logic             vsync;
`ifdef COLORCLK_TRIM_EN
   logic [7:0]       trim;
`endif
   logic [INC_W-1:0] dds_inc;
   logic             dds_en;
   logic             dds_clr;
   logic             mode_cur;
   logic             busy;
   logic             ready;

   modport master (
`ifdef COLORCLK_TRIM_EN
      input  trim,
`endif
      input  mode_req, en_req, vsync,
      output dds_inc, dds_en, dds_clr, mode_cur, busy, ready
   );

   modport slave (
`ifdef COLORCLK_TRIM_EN
      output trim,
`endif
      output mode_req, en_req, vsync,
      input  dds_inc, dds_en, dds_clr, mode_cur, busy, ready
   );
endinterface

// File: rtl/colorclk_ctrl.sv
// Colour-subcarrier DDS sequencer. Applies PAL/NTSC and enable changes only at a
// frame boundary (or after a vsync timeout), muting the carrier across the switch.
// Optional macro: COLORCLK_TRIM_EN adds a signed trim added to the increment word.
// Ports:
//   clk    DDS clock
//   rst_n  asynchronous active-low reset
//   bus    colorclk_ctrl_if.master (requests, vsync, DDS control, status)
module colorclk_ctrl #(
   parameter logic [28:0] INC_PAL       = 29'd95211238,
   parameter logic [28:0] INC_NTSC      = 29'd76870144,
   parameter int unsigned MUTE_CYCLES   = 16,
   parameter int unsigned SETTLE_CYCLES = 1024,
   parameter int unsigned WAIT_TIMEOUT  = 1048575
) (
   input  logic            clk,
   input  logic            rst_n,
   colorclk_ctrl_if.master bus
);
   localparam int unsigned INC_W   = 29;
   localparam int unsigned CNT_MAX = (MUTE_CYCLES > SETTLE_CYCLES) ? MUTE_CYCLES : SETTLE_CYCLES;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned TMO_W   = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {S_RUN, S_WAIT_VS, S_MUTE, S_LOAD, S_SETTLE} state_e;

   state_e           state_q, state_d;
   logic             mode_s1_q, mode_s_q, en_s1_q, en_s_q;
   logic             vs_q, vs_rise_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [INC_W-1:0] dds_inc_q, dds_inc_d;
   logic             dds_en_q, dds_en_d;
   logic             dds_clr_q, dds_clr_d;
   logic             mode_cur_q, mode_cur_d;
   logic             en_cur_q, en_cur_d;
   logic             busy_q, busy_d;
   logic             ready_q, ready_d;
   logic             trim_pend_c;
   logic [INC_W-1:0] trim_ext_c;
   logic             pending_c;

   // Request synchronisers and registered vsync rising-edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_s1_q <= 1'b0;
         mode_s_q  <= 1'b0;
         en_s1_q   <= 1'b0;
         en_s_q    <= 1'b0;
         vs_q      <= 1'b0;
         vs_rise_q <= 1'b0;
      end else begin
         mode_s1_q <= bus.mode_req;
         mode_s_q  <= mode_s1_q;
         en_s1_q   <= bus.en_req;
         en_s_q    <= en_s1_q;
         vs_q      <= bus.vsync;
         vs_rise_q <= bus.vsync & ~vs_q;
      end
   end

`ifdef COLORCLK_TRIM_EN
   logic [7:0] trim_s1_q, trim_s_q, trim_cur_q;

   // Trim synchroniser; applied value captured in LOAD alongside mode/enable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trim_s1_q  <= 8'd0;
         trim_s_q   <= 8'd0;
         trim_cur_q <= 8'd0;
      end else begin
         trim_s1_q <= bus.trim;
         trim_s_q  <= trim_s1_q;
         if (state_q == S_LOAD) trim_cur_q <= trim_s_q;
      end
   end

   assign trim_pend_c = (trim_s_q != trim_cur_q);
   assign trim_ext_c  = {{(INC_W-8){trim_s_q[7]}}, trim_s_q};
`else
   assign trim_pend_c = 1'b0;
   assign trim_ext_c  = '0;
`endif

   assign pending_c = ({en_s_q, mode_s_q} != {en_cur_q, mode_cur_q}) | trim_pend_c;

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_RUN;
         cnt_q      <= '0;
         tmo_q      <= '0;
         dds_inc_q  <= INC_PAL;
         dds_en_q   <= 1'b0;
         dds_clr_q  <= 1'b0;
         mode_cur_q <= 1'b0;
         en_cur_q   <= 1'b0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tmo_q      <= tmo_d;
         dds_inc_q  <= dds_inc_d;
         dds_en_q   <= dds_en_d;
         dds_clr_q  <= dds_clr_d;
         mode_cur_q <= mode_cur_d;
         en_cur_q   <= en_cur_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tmo_d      = tmo_q;
      dds_inc_d  = dds_inc_q;
      dds_en_d   = dds_en_q;
      dds_clr_d  = 1'b0;
      mode_cur_d = mode_cur_q;
      en_cur_d   = en_cur_q;
      busy_d     = busy_q;
      ready_d    = ready_q;

      unique case (state_q)
         S_RUN: begin
            dds_en_d = en_cur_q;
            ready_d  = en_cur_q;
            busy_d   = 1'b0;
            if (pending_c) begin
               state_d = S_WAIT_VS;
               busy_d  = 1'b1;
               tmo_d   = '0;
            end
         end
         S_WAIT_VS: begin
            if (!pending_c) begin
               // Request reverted before the switch point: nothing to do
               state_d = S_RUN;
               busy_d  = 1'b0;
            end else if (vs_rise_q || (tmo_q == TMO_W'(WAIT_TIMEOUT))) begin
               state_d  = S_MUTE;
               cnt_d    = '0;
               dds_en_d = 1'b0;
               ready_d  = 1'b0;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         S_MUTE: begin
            dds_en_d = 1'b0;
            ready_d  = 1'b0;
            if (cnt_q == CNT_W'(MUTE_CYCLES - 1)) state_d = S_LOAD;
            else                                  cnt_d   = cnt_q + CNT_W'(1);
         end
         S_LOAD: begin
            // Word and clear land while the carrier is still muted
            en_cur_d   = en_s_q;
            mode_cur_d = mode_s_q;
            dds_inc_d  = (mode_s_q ? INC_NTSC : INC_PAL) + trim_ext_c;
            dds_clr_d  = 1'b1;
            dds_en_d   = 1'b0;
            ready_d    = 1'b0;
            cnt_d      = '0;
            state_d    = S_SETTLE;
         end
         S_SETTLE: begin
            dds_en_d = en_cur_q;
            ready_d  = 1'b0;
            if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
               state_d = S_RUN;
               ready_d = en_cur_q;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   assign bus.dds_inc  = dds_inc_q;
   assign bus.dds_en   = dds_en_q;
   assign bus.dds_clr  = dds_clr_q;
   assign bus.mode_cur = mode_cur_q;
   assign bus.busy     = busy_q;
   assign bus.ready    = ready_q;
endmodule

// File: tb/tb_colorclk_ctrl.sv
// Testbench for colorclk_ctrl: scoreboard of expected applied words, popped on dds_clr.
module tb_colorclk_ctrl;
   localparam int unsigned WT = 2000;
   localparam int unsigned MC = 16;
   localparam int unsigned SC = 1024;
   localparam logic [28:0] PAL  = 29'd95211238;
   localparam logic [28:0] NTSC = 29'd76870144;

   typedef struct packed {
      logic [28:0] inc;
      logic        mode;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          clr_seen = 0;
   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        prev_clr = 1'b0;
   logic        prev_en  = 1'b0;
   logic [28:0] prev_inc = PAL;

   always #5 clk = ~clk;

   colorclk_ctrl_if bus();

   colorclk_ctrl #(
      .MUTE_CYCLES  (MC),
      .SETTLE_CYCLES(SC),
      .WAIT_TIMEOUT (WT)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

`ifdef COLORCLK_TRIM_EN
   initial bus.trim = 8'd0;
`endif

   // Scoreboard pop on every clear pulse, plus pulse-width and word-stability watch
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.dds_clr) begin
            clr_seen++;
            n_tests++;
            if (prev_clr) begin
               n_fail++;
               $display("FAIL clr_width: dds_clr high two cycles running");
            end else if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_clr: dds_clr with nothing expected, dds_inc=%0d", bus.dds_inc);
            end else begin
               mon_e = sb_q.pop_front();
               if ({bus.dds_inc, bus.mode_cur, bus.dds_en} !== {mon_e.inc, mon_e.mode, 1'b0}) begin
                  n_fail++;
                  $display("FAIL load_word: inc=%0d mode=%0d en=%0d expected inc=%0d mode=%0d en=0",
                           bus.dds_inc, bus.mode_cur, bus.dds_en, mon_e.inc, mon_e.mode);
               end
            end
         end
         if (prev_en && bus.dds_en && (bus.dds_inc !== prev_inc)) begin
            n_tests++;
            n_fail++;
            $display("FAIL inc_stable: dds_inc %0d -> %0d while dds_en=1", prev_inc, bus.dds_inc);
         end
      end
      prev_clr = bus.dds_clr;
      prev_en  = bus.dds_en;
      prev_inc = bus.dds_inc;
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.mode_req = 1'b0;
      bus.en_req   = 1'b0;
      bus.vsync    = 1'b0;
      cycles(3);
      n_tests++; if (bus.dds_inc  !== PAL)  begin n_fail++; $display("FAIL rst_inc: got %0d want %0d", bus.dds_inc, PAL); end
      n_tests++; if (bus.dds_en   !== 1'b0) begin n_fail++; $display("FAIL rst_en: got %b want 0", bus.dds_en); end
      n_tests++; if (bus.dds_clr  !== 1'b0) begin n_fail++; $display("FAIL rst_clr: got %b want 0", bus.dds_clr); end
      n_tests++; if (bus.mode_cur !== 1'b0) begin n_fail++; $display("FAIL rst_mode: got %b want 0", bus.mode_cur); end
      n_tests++; if (bus.busy     !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
      n_tests++; if (bus.ready    !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", bus.ready); end
      rst_n = 1'b1;
      cycles(2);
   endtask

   // Enable with no vsync: switch forced by the wait timeout
   task automatic test_enable_timeout();
      int t;
      sb_q.push_back('{inc: PAL, mode: 1'b0});
      bus.en_req = 1'b1;
      t = 0;
      while (!bus.dds_clr && t < int'(WT + MC + 50)) begin cycles(1); t++; end
      n_tests++;
      if (!bus.dds_clr || t < int'(WT + MC) || t > int'(WT + MC + 8)) begin
         n_fail++; $display("FAIL timeout_clr: clr=%b after %0d cycles, want clr within %0d..%0d", bus.dds_clr, t, WT + MC, WT + MC + 8);
      end
      t = 0;
      while (!bus.ready && t < int'(SC + 50)) begin cycles(1); t++; end
      n_tests++;
      if (!bus.ready || t < int'(SC - 1) || t > int'(SC + 1)) begin
         n_fail++; $display("FAIL settle_ready: ready=%b after %0d cycles, want ~%0d", bus.ready, t, SC);
      end
      n_tests++;
      if ({bus.busy, bus.dds_en, bus.mode_cur, bus.dds_inc} !== {1'b0, 1'b1, 1'b0, PAL}) begin
         n_fail++; $display("FAIL pal_run: busy=%b en=%b mode=%b inc=%0d want 0 1 0 %0d", bus.busy, bus.dds_en, bus.mode_cur, bus.dds_inc, PAL);
      end
   endtask

   // PAL -> NTSC at a vsync 500 cycles after the request
   task automatic test_mode_switch();
      int t;
      int low;
      sb_q.push_back('{inc: NTSC, mode: 1'b1});
      bus.mode_req = 1'b1;
      cycles(500);
      n_tests++;
      if ({bus.busy, bus.dds_en, bus.dds_inc} !== {1'b1, 1'b1, PAL}) begin
         n_fail++; $display("FAIL wait_vs: busy=%b en=%b inc=%0d want 1 1 %0d", bus.busy, bus.dds_en, bus.dds_inc, PAL);
      end
      bus.vsync = 1'b1;
      low = 0;
      for (int i = 0; i < int'(MC + 60); i++) begin
         cycles(1);
         if (i == 2) bus.vsync = 1'b0;
         if (!bus.dds_en) low++;
      end
      n_tests++;
      if (low < int'(MC) || low > int'(MC + 3)) begin
         n_fail++; $display("FAIL mute_len: dds_en low %0d cycles, want %0d..%0d", low, MC, MC + 3);
      end
      n_tests++;
      if ({bus.dds_inc, bus.mode_cur} !== {NTSC, 1'b1}) begin
         n_fail++; $display("FAIL ntsc_word: inc=%0d mode=%b want %0d 1", bus.dds_inc, bus.mode_cur, NTSC);
      end
      t = 0;
      while (!bus.ready && t < int'(SC + 50)) begin cycles(1); t++; end
      n_tests++;
      if ({bus.ready, bus.busy} !== 2'b10) begin
         n_fail++; $display("FAIL ntsc_ready: ready=%b busy=%b want 1 0", bus.ready, bus.busy);
      end
   endtask

   // Request flips and reverts before any vsync: no switch
   task automatic test_revert();
      int   clr0;
      logic dropped;
      clr0 = clr_seen;
      dropped = 1'b0;
      bus.mode_req = 1'b0;
      cycles(10);
      n_tests++;
      if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL revert_busy: busy=%b want 1", bus.busy); end
      bus.mode_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cycles(1);
         if (!bus.dds_en) dropped = 1'b1;
      end
      n_tests++;
      if ({bus.busy, bus.mode_cur, dropped} !== 3'b010 || clr_seen != clr0) begin
         n_fail++; $display("FAIL revert: busy=%b mode=%b muted=%b clrs=%0d want 0 1 0 0", bus.busy, bus.mode_cur, dropped, clr_seen - clr0);
      end
   endtask

   // New request during SETTLE: first sequence finishes, second follows
   task automatic test_back_to_back();
      int  clr0;
      int  t;
      logic done;
      clr0 = clr_seen;
      sb_q.push_back('{inc: PAL, mode: 1'b0});
      bus.mode_req = 1'b0;
      cycles(5);
      bus.vsync = 1'b1; cycles(3); bus.vsync = 1'b0;
      t = 0;
      while (clr_seen == clr0 && t < 100) begin cycles(1); t++; end
      cycles(100);
      sb_q.push_back('{inc: NTSC, mode: 1'b1});
      bus.mode_req = 1'b1;
      n_tests++;
      if ({bus.busy, bus.ready, bus.mode_cur} !== 3'b100) begin
         n_fail++; $display("FAIL settle_state: busy=%b ready=%b mode=%b want 1 0 0", bus.busy, bus.ready, bus.mode_cur);
      end
      done = 1'b0;
      for (int i = 0; i < 8000 && !done; i++) begin
         bus.vsync = ((i % 200) < 3);
         cycles(1);
         done = (sb_q.size() == 0) && bus.ready && !bus.busy;
      end
      bus.vsync = 1'b0;
      n_tests++;
      if (!done || clr_seen != clr0 + 2 || {bus.mode_cur, bus.dds_inc} !== {1'b1, NTSC}) begin
         n_fail++; $display("FAIL back_to_back: done=%b clrs=%0d mode=%b inc=%0d want 1 2 1 %0d", done, clr_seen - clr0, bus.mode_cur, bus.dds_inc, NTSC);
      end
   endtask

   // Disable request: same sequence, carrier stays off, ready never rises
   task automatic test_disable();
      int   clr0;
      logic on_seen;
      logic fin;
      clr0 = clr_seen;
      on_seen = 1'b0;
      fin = 1'b0;
      sb_q.push_back('{inc: NTSC, mode: 1'b1});
      bus.en_req = 1'b0;
      cycles(5);
      bus.vsync = 1'b1;
      for (int i = 0; i < int'(SC + 200) && !fin; i++) begin
         cycles(1);
         if (i == 2) bus.vsync = 1'b0;
         if (clr_seen != clr0) begin
            if (bus.dds_en || bus.ready) on_seen = 1'b1;
            fin = !bus.busy;
         end
      end
      bus.vsync = 1'b0;
      n_tests++;
      if (!fin || on_seen || {bus.dds_en, bus.ready, bus.busy} !== 3'b000) begin
         n_fail++; $display("FAIL disable: fin=%b on_during=%b en=%b ready=%b busy=%b want 1 0 0 0 0", fin, on_seen, bus.dds_en, bus.ready, bus.busy);
      end
   endtask

   // Async reset while muted mid-switch
   task automatic test_reset_mid_mute();
      bus.en_req = 1'b1;
      cycles(5);
      bus.vsync = 1'b1;
      cycles(6);
      bus.vsync = 1'b0;
      n_tests++;
      if ({bus.busy, bus.dds_en, bus.mode_cur} !== 3'b101) begin
         n_fail++; $display("FAIL in_mute: busy=%b en=%b mode=%b want 1 0 1", bus.busy, bus.dds_en, bus.mode_cur);
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({bus.dds_inc, bus.mode_cur, bus.dds_en, bus.dds_clr, bus.busy, bus.ready} !== {PAL, 5'b00000}) begin
         n_fail++; $display("FAIL async_rst: inc=%0d mode=%b en=%b clr=%b busy=%b ready=%b want %0d 0 0 0 0 0",
                            bus.dds_inc, bus.mode_cur, bus.dds_en, bus.dds_clr, bus.busy, bus.ready, PAL);
      end
      sb_q.delete();
      bus.en_req   = 1'b0;
      bus.mode_req = 1'b0;
      cycles(2);
      rst_n = 1'b1;
      cycles(10);
      n_tests++;
      if ({bus.busy, bus.dds_en, bus.dds_inc} !== {2'b00, PAL}) begin
         n_fail++; $display("FAIL post_rst: busy=%b en=%b inc=%0d want 0 0 %0d", bus.busy, bus.dds_en, bus.dds_inc, PAL);
      end
   endtask

   initial begin
      test_reset();
      test_enable_timeout();
      test_mode_switch();
      test_revert();
      test_back_to_back();
      test_disable();
      test_reset_mid_mute();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, %0d failed so far", n_fail);
      $fatal(1, "watchdog");
   end
endmodule
